// File: rtl/dsram_axi_bridge.sv
// ----------------------------------------------------------------------------
// dsram_axi_bridge
//
// Converts the pipeline's single-cycle data SRAM request (from EX) into one
// single-beat AXI4 transaction. While the transaction is outstanding the
// pipeline is stalled. Completed read data is kept in a register that MEM
// consumes.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   data_sram_*_i            request from EX: enable, byte write enables
//                            (0000 = read), byte address, lane-aligned data
//   data_sram_rdata_o        word returned by the most recent read
//   stallreq_o               stall request while an access is outstanding
//   ar*_o / arready_i        AXI4 read address channel
//   r*_i  / rready_o         AXI4 read data channel
//   aw*_o / awready_i        AXI4 write address channel
//   w*_o  / wready_i         AXI4 write data channel
//   b*_i  / bready_o         AXI4 write response channel
// ----------------------------------------------------------------------------
module dsram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        data_sram_en_i,
  input  logic [3:0]  data_sram_wen_i,
  input  logic [31:0] data_sram_addr_i,
  input  logic [31:0] data_sram_wdata_i,
  output logic [31:0] data_sram_rdata_o,
  output logic        stallreq_o,

  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,

  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,

  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [7:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,

  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,

  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [3:0]  wen_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;

  // Responses and IDs are not acted on: the bridge never aborts or retries.
  logic        unusedInputs;
  assign unusedInputs = ^{rid_i, rresp_i, bid_i, bresp_i};

  // A write channel counts as finished if it already handshook earlier
  // (valid dropped) or handshakes in the current cycle.
  logic awDone;
  logic wDone;
  assign awDone = ~awvalid_q | awready_i;
  assign wDone  = ~wvalid_q  | wready_i;

  // Main FSM: state, latched request and all handshake outputs are registered
  // here so they change only on clock edges and clear instantly on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wen_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_sram_en_i) begin
            addr_q  <= data_sram_addr_i;
            wen_q   <= data_sram_wen_i;
            wdata_q <= data_sram_wdata_i;
            if (data_sram_wen_i == 4'b0000) begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
            end else begin
              state_q   <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end
        end

        RD_ADDR: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid_i && rlast_i) begin
            rdata_q  <= rdata_i;
            rready_q <= 1'b0;
            state_q  <= DONE;
          end
        end

        WR_REQ: begin
          if (awvalid_q && awready_i) begin
            awvalid_q <= 1'b0;
          end
          if (wvalid_q && wready_i) begin
            wvalid_q <= 1'b0;
          end
          if (awDone && wDone) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid_i) begin
            bready_q <= 1'b0;
            state_q  <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q   <= IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so the pipeline freezes in the request cycle
  // itself; it is gated by rst so it drops the moment reset is asserted.
  assign stallreq_o = ~rst &
                      (((state_q == IDLE) & data_sram_en_i) |
                       ((state_q != IDLE) & (state_q != DONE)));

  assign data_sram_rdata_o = rdata_q;

  assign arid_o    = AXI_ID;
  assign araddr_o  = {addr_q[31:2], 2'b00};
  assign arlen_o   = 8'd0;
  assign arsize_o  = 3'b010;
  assign arburst_o = 2'b01;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

  assign awid_o    = AXI_ID;
  assign awaddr_o  = {addr_q[31:2], 2'b00};
  assign awlen_o   = 8'd0;
  assign awsize_o  = 3'b010;
  assign awburst_o = 2'b01;
  assign awvalid_o = awvalid_q;

  assign wdata_o   = wdata_q;
  assign wstrb_o   = wen_q;
  assign wlast_o   = 1'b1;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;

endmodule

// File: tb/tb_dsram_axi_bridge.sv
// ----------------------------------------------------------------------------
// tb_dsram_axi_bridge
//
// Directed bench for dsram_axi_bridge. A table of single transactions is run
// against a zero-wait slave, and hand-written sequences cover slave wait
// states, back-to-back requests and reset in the middle of a read.
// Inputs change on the falling clock edge; outputs are sampled 1ns later.
// ----------------------------------------------------------------------------
module tb_dsram_axi_bridge;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdataIn;
  logic [31:0] rdataOut;
  logic        stallreq;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int tests = 0;
  int fails = 0;

  dsram_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk               (clk),
    .rst               (rst),
    .data_sram_en_i    (en),
    .data_sram_wen_i   (wen),
    .data_sram_addr_i  (addr),
    .data_sram_wdata_i (wdataIn),
    .data_sram_rdata_o (rdataOut),
    .stallreq_o        (stallreq),
    .arid_o            (arid),
    .araddr_o          (araddr),
    .arlen_o           (arlen),
    .arsize_o          (arsize),
    .arburst_o         (arburst),
    .arvalid_o         (arvalid),
    .arready_i         (arready),
    .rid_i             (rid),
    .rdata_i           (rdata),
    .rresp_i           (rresp),
    .rlast_i           (rlast),
    .rvalid_i          (rvalid),
    .rready_o          (rready),
    .awid_o            (awid),
    .awaddr_o          (awaddr),
    .awlen_o           (awlen),
    .awsize_o          (awsize),
    .awburst_o         (awburst),
    .awvalid_o         (awvalid),
    .awready_i         (awready),
    .wdata_o           (wdata),
    .wstrb_o           (wstrb),
    .wlast_o           (wlast),
    .wvalid_o          (wvalid),
    .wready_i          (wready),
    .bid_i             (bid),
    .bresp_i           (bresp),
    .bvalid_i          (bvalid),
    .bready_o          (bready)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] slaveRdata;
    logic [31:0] expAddr;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[6];

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave that answers every channel immediately; IDs/responses carry junk
  // values that the bridge must ignore.
  task automatic zeroWaitSlave();
    arready = 1'b1;
    rvalid  = 1'b1;
    rlast   = 1'b1;
    awready = 1'b1;
    wready  = 1'b1;
    bvalid  = 1'b1;
    rid     = 4'hE;
    rresp   = 2'b10;
    bid     = 4'hD;
    bresp   = 2'b11;
  endtask

  // Run one table entry as a complete transaction against the current slave.
  task automatic applyStimulus(input vec_t v);
    int  stallCnt;
    bit  done;
    bit  sawAddr;
    bit  sawW;
    bit  wrongChan;
    @(negedge clk);
    en      = 1'b1;
    wen     = v.wen;
    addr    = v.addr;
    wdataIn = v.wdata;
    rdata   = v.slaveRdata;
    #1;
    checkOutput("request cycle stall", {31'd0, stallreq}, 32'd1);
    stallCnt  = 1;
    done      = 1'b0;
    sawAddr   = 1'b0;
    sawW      = 1'b0;
    wrongChan = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      #1;
      if (stallreq) stallCnt++;
      else done = 1'b1;
      if ((v.wen == 4'b0000 && (awvalid || wvalid)) || (v.wen != 4'b0000 && arvalid))
        wrongChan = 1'b1;
      if (arvalid && !sawAddr) begin
        sawAddr = 1'b1;
        checkOutput("araddr", araddr, v.expAddr);
        checkOutput("ar id/len/size/burst", {15'd0, arid, arlen, arsize, arburst},
                    {15'd0, 4'd1, 8'd0, 3'b010, 2'b01});
      end
      if (awvalid && !sawAddr) begin
        sawAddr = 1'b1;
        checkOutput("awaddr", awaddr, v.expAddr);
        checkOutput("aw id/len/size/burst", {15'd0, awid, awlen, awsize, awburst},
                    {15'd0, 4'd1, 8'd0, 3'b010, 2'b01});
      end
      if (wvalid && !sawW) begin
        sawW = 1'b1;
        checkOutput("wdata", wdata, v.wdata);
        checkOutput("wstrb/wlast", {27'd0, wstrb, wlast}, {27'd0, v.wen, 1'b1});
      end
    end
    checkOutput("transaction completes", {31'd0, done}, 32'd1);
    checkOutput("stall cycle count", stallCnt, 32'd3);
    checkOutput("address phase issued", {31'd0, sawAddr}, 32'd1);
    checkOutput("correct channel used", {31'd0, wrongChan}, 32'd0);
    if (v.wen != 4'b0000)
      checkOutput("write data issued", {31'd0, sawW}, 32'd1);
    @(negedge clk);
    en = 1'b0;
    #1;
    checkOutput("idle stall", {31'd0, stallreq}, 32'd0);
    checkOutput("rdata after txn", rdataOut, v.expRdata);
  endtask

  initial begin
    vecs[0] = '{4'b0000, 32'h8000_1236, 32'h0,         32'hA1B2_C3D4, 32'h8000_1234, 32'hA1B2_C3D4};
    vecs[1] = '{4'b1000, 32'h1000_0003, 32'h5500_0000, 32'h0,         32'h1000_0000, 32'hA1B2_C3D4};
    vecs[2] = '{4'b0000, 32'h0000_0001, 32'h0,         32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
    vecs[3] = '{4'b1111, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0,         32'hFFFF_FFFC, 32'h1234_5678};
    vecs[4] = '{4'b0011, 32'h2000_0006, 32'h0000_BEEF, 32'h0,         32'h2000_0004, 32'h1234_5678};
    vecs[5] = '{4'b0000, 32'hFFFF_FFFE, 32'h0,         32'hCAFE_F00D, 32'hFFFF_FFFC, 32'hCAFE_F00D};

    rst     = 1'b1;
    en      = 1'b0;
    wen     = 4'b0000;
    addr    = 32'h0;
    wdataIn = 32'h0;
    rdata   = 32'h0;
    zeroWaitSlave();

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset valids/readys/stall",
                {26'd0, arvalid, rready, awvalid, wvalid, bready, stallreq}, 32'd0);
    checkOutput("reset rdata", rdataOut, 32'd0);
    checkOutput("reset araddr", araddr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table of single transactions against a zero-wait slave.
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Write where wready arrives 3 cycles after the address handshake.
    awready = 1'b1; wready = 1'b0; bvalid = 1'b0;
    @(negedge clk);
    en = 1'b1; wen = 4'b1000; addr = 32'h1000_0003; wdataIn = 32'h5500_0000;
    #1;
    checkOutput("wr req stall", {31'd0, stallreq}, 32'd1);
    @(negedge clk); #1;
    checkOutput("wr c1 aw/w/b", {29'd0, awvalid, wvalid, bready}, 32'b110);
    checkOutput("wr awaddr", awaddr, 32'h1000_0000);
    checkOutput("wr wstrb", {28'd0, wstrb}, 32'b1000);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) wready = 1'b1;
      #1;
      checkOutput("wr wait aw/w/b", {29'd0, awvalid, wvalid, bready}, 32'b010);
      checkOutput("wr wait stall", {31'd0, stallreq}, 32'd1);
    end
    @(negedge clk);
    wready = 1'b0; bvalid = 1'b1;
    #1;
    checkOutput("wr resp aw/w/b", {29'd0, awvalid, wvalid, bready}, 32'b001);
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    checkOutput("wr done stall", {31'd0, stallreq}, 32'd0);
    checkOutput("wr done bready", {31'd0, bready}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    zeroWaitSlave();

    // Read with arready held low for 5 cycles.
    arready = 1'b0;
    @(negedge clk);
    en = 1'b1; wen = 4'b0000; addr = 32'h5000_0002; rdata = 32'h1357_2468;
    #1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      checkOutput("ar wait arvalid", {31'd0, arvalid}, 32'd1);
      checkOutput("ar wait araddr", araddr, 32'h5000_0000);
      checkOutput("ar wait stall", {31'd0, stallreq}, 32'd1);
    end
    @(negedge clk);
    arready = 1'b1;
    #1;
    checkOutput("ar handshake arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk);
    arready = 1'b0;
    #1;
    checkOutput("rd data arvalid/rready", {30'd0, arvalid, rready}, 32'b01);
    @(negedge clk); #1;
    checkOutput("rd slow done stall", {31'd0, stallreq}, 32'd0);
    checkOutput("rd slow rdata", rdataOut, 32'h1357_2468);
    @(negedge clk);
    en = 1'b0;
    zeroWaitSlave();

    // Back-to-back read then write with en held high through DONE.
    @(negedge clk);
    en = 1'b1; wen = 4'b0000; addr = 32'h3000_0008; rdata = 32'h0BAD_CAFE;
    #1;
    @(negedge clk); #1;
    checkOutput("b2b rd arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk); #1;
    checkOutput("b2b rd rready", {31'd0, rready}, 32'd1);
    @(negedge clk);
    wen = 4'b0101; addr = 32'h3000_000C; wdataIn = 32'h00AA_00BB;
    #1;
    checkOutput("b2b done ignores en", {30'd0, stallreq, awvalid}, 32'd0);
    checkOutput("b2b rd rdata", rdataOut, 32'h0BAD_CAFE);
    @(negedge clk); #1;
    checkOutput("b2b idle request", {30'd0, stallreq, awvalid}, 32'b10);
    @(negedge clk); #1;
    checkOutput("b2b wr aw/w", {30'd0, awvalid, wvalid}, 32'b11);
    checkOutput("b2b wr awaddr", awaddr, 32'h3000_000C);
    @(negedge clk); #1;
    checkOutput("b2b wr bready", {31'd0, bready}, 32'd1);
    @(negedge clk);
    en = 1'b0;
    #1;
    checkOutput("b2b wr done stall", {31'd0, stallreq}, 32'd0);
    @(negedge clk); #1;
    checkOutput("b2b rdata unchanged by write", rdataOut, 32'h0BAD_CAFE);

    // Reset asserted while waiting in RD_DATA.
    rvalid = 1'b0;
    @(negedge clk);
    en = 1'b1; wen = 4'b0000; addr = 32'h4000_0010; rdata = 32'h7777_7777;
    #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("pre-reset rready", {31'd0, rready}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset outputs",
                {26'd0, arvalid, rready, awvalid, wvalid, bready, stallreq}, 32'd0);
    checkOutput("async reset rdata", rdataOut, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    zeroWaitSlave();
    applyStimulus('{4'b0000, 32'h4000_0013, 32'h0, 32'h9999_AAAA, 32'h4000_0010, 32'h9999_AAAA});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsram_axi_bridge.md
DSRAM_AXI_BRIDGE -- requirements
Module: dsram_axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'd1: value driven on arid and awid.
REQ-002 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 data_sram_en  input  1  data access request from EX; held stable while stallreq is 1.
REQ-005 data_sram_wen  input  4  byte write enables; 4'b0000 means read.
REQ-006 data_sram_addr  input  32  byte address of the access.
REQ-007 data_sram_wdata  input  32  store data, already lane-aligned.
REQ-008 data_sram_rdata  output  32  full aligned word of the last completed read, consumed by MEM.
REQ-009 stallreq  output  1  pipeline stall request for the outstanding data access.
REQ-010 arid/araddr/arlen/arsize/arburst/arvalid  output  4/32/8/3/2/1  AXI4 read address channel.
REQ-011 arready  input  1  AXI4 read address handshake.
REQ-012 rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1  AXI4 read data channel.
REQ-013 rready  output  1  AXI4 read data handshake.
REQ-014 awid/awaddr/awlen/awsize/awburst/awvalid  output  4/32/8/3/2/1  AXI4 write address channel.
REQ-015 awready  input  1  AXI4 write address handshake.
REQ-016 wdata/wstrb/wlast/wvalid  output  32/4/1/1  AXI4 write data channel.
REQ-017 wready  input  1  AXI4 write data handshake.
REQ-018 bid/bresp/bvalid  input  4/2/1  AXI4 write response channel.
REQ-019 bready  output  1  AXI4 write response handshake.

Function
REQ-020 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; one transaction outstanding at most.
REQ-021 In IDLE with data_sram_en=1, the block SHALL latch addr/wen/wdata and go to RD_ADDR if wen==0, else WR_REQ.
REQ-022 Addresses SHALL be word aligned ({addr[31:2],2'b00}); arlen=awlen=0, arsize=awsize=3'b010, arburst=awburst=2'b01, wlast=1, wstrb=latched wen.
REQ-023 RD_ADDR: arvalid=1 until the arvalid&arready cycle; then go to RD_DATA; arvalid SHALL NOT drop before arready.
REQ-024 RD_DATA: rready=1; on rvalid&rlast, capture rdata into the rdata register and go to DONE.
REQ-025 WR_REQ: awvalid and wvalid asserted together on entry; each deasserts independently after its own handshake; go to WR_RESP once both handshakes are done (same or different cycles).
REQ-026 WR_RESP: bready=1; on bvalid go to DONE.
REQ-027 DONE: one cycle, then IDLE unconditionally; data_sram_en SHALL be ignored in DONE.
REQ-028 stallreq SHALL equal (IDLE & data_sram_en) | (state not in {IDLE, DONE}), combinationally.
REQ-029 data_sram_rdata SHALL hold its value from the capture in REQ-024 until the next read capture; writes do not change it.
REQ-030 rresp, bresp, rid and bid SHALL be ignored; no abort of an issued transaction.
REQ-031 Best-case latency: read or write with zero-wait slave = request cycle + 2 handshake cycles + DONE; stallreq high for exactly 3 cycles.

Reset
REQ-032 Asserting rst SHALL immediately force state=IDLE and arvalid, rready, awvalid, wvalid, bready, stallreq to 0, regardless of the transaction in flight.
REQ-033 Reset SHALL clear data_sram_rdata and all latched request registers to 0.

Verification
REQ-034 Read, addr=0x8000_1236, wen=0, slave ready immediately, rdata=0xA1B2C3D4 -> araddr=0x8000_1234, arsize=2, stallreq high 3 cycles, data_sram_rdata=0xA1B2C3D4 held after.
REQ-035 Write, addr=0x1000_0003, wen=4'b1000, wdata=0x5500_0000; wready 3 cycles after awready -> awaddr=0x1000_0000, wstrb=4'b1000, awvalid drops after its handshake, wvalid stays until wready, bready only after both.
REQ-036 arready held low 5 cycles -> arvalid and araddr stable all 5 cycles; stallreq remains 1.
REQ-037 Back-to-back read then write -> second request starts only from IDLE after DONE; data_sram_rdata unchanged by the write.
REQ-038 rst asserted in RD_DATA -> all valid/ready outputs and stallreq 0 asynchronously; next request after release completes normally.
